// File: rtl/silencer_stepper.sv
// rtl/silencer_stepper.sv - slew-rate limiter for per-channel duty/phase targets
//
// Every UPDATE_CYCLE clocks a sweep walks all DEPTH channels, one per clock,
// moving each silenced duty/phase value a bounded step toward its target.
//
// Ports:
//   CLK           system clock, rising edge
//   RST           synchronous active-high reset
//   UPDATE_CYCLE  sweep period in CLK cycles (0 = no sweeps)
//   STEP_DUTY     max duty change per sweep, latched at sweep start
//   STEP_PHASE    max phase change per sweep, latched at sweep start
//   CYCLE[i]      per-channel period
//   DUTY[i]       duty target (clamped to CYCLE[i])
//   PHASE[i]      phase target (ignored when >= CYCLE[i])
//   DUTY_S[i]     silenced duty, registered
//   PHASE_S[i]    silenced phase, registered
//   BUSY          sweep in progress
//   DONE          one-cycle pulse when a sweep finishes
//   OVERRUN       sticky, a sweep tick arrived while BUSY
//
// Build option: SILENCER_PHASE_WRAP_EN folds the phase difference onto the
// shortest path around the cycle and reduces the result modulo CYCLE[i].
// Without it the phase steps linearly and saturates inside 0..CYCLE[i]-1.

module silencer_stepper #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      UPDATE_CYCLE,
    input  logic [WIDTH-1:0] STEP_DUTY,
    input  logic [WIDTH-1:0] STEP_PHASE,
    input  logic [WIDTH-1:0] CYCLE   [0:DEPTH-1],
    input  logic [WIDTH-1:0] DUTY    [0:DEPTH-1],
    input  logic [WIDTH-1:0] PHASE   [0:DEPTH-1],
    output logic [WIDTH-1:0] DUTY_S  [0:DEPTH-1],
    output logic [WIDTH-1:0] PHASE_S [0:DEPTH-1],
    output logic             BUSY,
    output logic             DONE,
    output logic             OVERRUN
);

    localparam int IW = $clog2(DEPTH + 1);
    localparam int SW = WIDTH + 2;
    // Index value of the closing cycle after the last channel.
    localparam logic [IW-1:0] IDX_END = IW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    sel;
    logic [15:0]      tick_cnt;
    logic [15:0]      period;
    logic             tick;
    logic [WIDTH-1:0] step_duty_q;
    logic [WIDTH-1:0] step_phase_q;

    logic [WIDTH-1:0] cyc;
    logic [WIDTH-1:0] duty_t;
    logic [WIDTH-1:0] phase_t;
    logic [WIDTH-1:0] cur_d;
    logic [WIDTH-1:0] cur_p;
    logic [WIDTH-1:0] dtgt;
    logic [WIDTH-1:0] duty_nx;
    logic [WIDTH-1:0] phase_nx;

    logic signed [SW-1:0] cyc_w;
    logic signed [SW-1:0] ddiff;
    logic signed [SW-1:0] dstep_w;
    logic signed [SW-1:0] pdiff;
    logic signed [SW-1:0] pfold;
    logic signed [SW-1:0] pstep_w;
    logic signed [SW-1:0] pmove;
    logic signed [SW-1:0] psum;
`ifdef SILENCER_PHASE_WRAP_EN
    logic signed [SW-1:0] half_w;
`endif

    // The period only reloads at a wrap (or while idle at zero), so a new
    // UPDATE_CYCLE never truncates or stretches the count in flight.
    assign tick = (period != 16'd0) && (tick_cnt == period - 16'd1);

    // During the closing cycle idx is DEPTH; park the read mux on channel 0.
    assign sel = (idx < IDX_END) ? idx : '0;

    always_comb begin
        cyc     = CYCLE[sel];
        duty_t  = DUTY[sel];
        phase_t = PHASE[sel];
        cur_d   = DUTY_S[sel];
        cur_p   = PHASE_S[sel];

        // Duty: clamp target to the period, then slew by at most STEP_DUTY.
        dtgt    = (duty_t > cyc) ? cyc : duty_t;
        ddiff   = $signed({2'b00, dtgt}) - $signed({2'b00, cur_d});
        dstep_w = $signed({2'b00, step_duty_q});
        if (ddiff > dstep_w) begin
            duty_nx = cur_d + step_duty_q;
        end else if (ddiff < -dstep_w) begin
            duty_nx = cur_d - step_duty_q;
        end else begin
            duty_nx = dtgt;
        end

        // Phase: difference carried with one extra bit of headroom so the
        // fold by +/-CYCLE cannot overflow.
        cyc_w   = $signed({2'b00, cyc});
        pdiff   = $signed({2'b00, phase_t}) - $signed({2'b00, cur_p});
`ifdef SILENCER_PHASE_WRAP_EN
        half_w  = $signed({3'b000, cyc[WIDTH-1:1]});
        if (pdiff > half_w) begin
            pfold = pdiff - cyc_w;
        end else if (pdiff <= -half_w) begin
            pfold = pdiff + cyc_w;
        end else begin
            pfold = pdiff;
        end
`else
        pfold   = pdiff;
`endif
        pstep_w = $signed({2'b00, step_phase_q});
        if (pfold > pstep_w) begin
            pmove = pstep_w;
        end else if (pfold < -pstep_w) begin
            pmove = -pstep_w;
        end else begin
            pmove = pfold;
        end
        psum = $signed({2'b00, cur_p}) + pmove;

        if (phase_t >= cyc) begin
            phase_nx = cur_p;
`ifdef SILENCER_PHASE_WRAP_EN
        end else if (psum < 0) begin
            phase_nx = WIDTH'(psum + cyc_w);
        end else if (psum >= cyc_w) begin
            phase_nx = WIDTH'(psum - cyc_w);
`else
        end else if (psum < 0) begin
            phase_nx = '0;
        end else if (psum >= cyc_w) begin
            phase_nx = WIDTH'(cyc_w - 1);
`endif
        end else begin
            phase_nx = WIDTH'(psum);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            idx          <= '0;
            tick_cnt     <= 16'd0;
            period       <= 16'd0;
            step_duty_q  <= '0;
            step_phase_q <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            OVERRUN      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                DUTY_S[i]  <= '0;
                PHASE_S[i] <= '0;
            end
        end else begin
            DONE <= 1'b0;

            if (period == 16'd0 || tick) begin
                tick_cnt <= 16'd0;
                period   <= UPDATE_CYCLE;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state        <= S_RUN;
                        BUSY         <= 1'b1;
                        idx          <= '0;
                        step_duty_q  <= STEP_DUTY;
                        step_phase_q <= STEP_PHASE;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        OVERRUN <= 1'b1;
                    end
                    // One closing cycle after the last channel lines DONE up
                    // with the register update of that channel being visible.
                    if (idx == IDX_END) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        DUTY_S[sel]  <= duty_nx;
                        PHASE_S[sel] <= phase_nx;
                        idx          <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_silencer_stepper.sv
// tb/tb_silencer_stepper.sv - self-checking bench for silencer_stepper

module tb_silencer_stepper;

    localparam int W = 13;
    localparam int D = 249;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [15:0]   UPDATE_CYCLE = 16'd0;
    logic [W-1:0]  STEP_DUTY = '0;
    logic [W-1:0]  STEP_PHASE = '0;
    logic [W-1:0]  cyc_a   [0:D-1];
    logic [W-1:0]  duty_a  [0:D-1];
    logic [W-1:0]  phase_a [0:D-1];
    logic [W-1:0]  duty_s  [0:D-1];
    logic [W-1:0]  phase_s [0:D-1];
    logic          busy;
    logic          done;
    logic          overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;
    int m_duty [D];
    int m_phase [D];
    int q_duty [$];
    int q_phase [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    silencer_stepper #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK),
        .RST(RST),
        .UPDATE_CYCLE(UPDATE_CYCLE),
        .STEP_DUTY(STEP_DUTY),
        .STEP_PHASE(STEP_PHASE),
        .CYCLE(cyc_a),
        .DUTY(duty_a),
        .PHASE(phase_a),
        .DUTY_S(duty_s),
        .PHASE_S(phase_s),
        .BUSY(busy),
        .DONE(done),
        .OVERRUN(overrun)
    );

    function automatic int model_duty(int cur, int tgt, int cyc, int step);
        int t;
        t = (tgt > cyc) ? cyc : tgt;
        if (t - cur > step) return cur + step;
        if (cur - t > step) return cur - step;
        return t;
    endfunction

    function automatic int model_phase(int cur, int tgt, int cyc, int step);
        int d;
        int n;
        if (tgt >= cyc) return cur;
        d = tgt - cur;
`ifdef SILENCER_PHASE_WRAP_EN
        if (d > cyc / 2) d = d - cyc;
        else if (d <= -(cyc / 2)) d = d + cyc;
`endif
        if (d > step) d = step;
        else if (d < -step) d = -step;
        n = cur + d;
`ifdef SILENCER_PHASE_WRAP_EN
        n = ((n % cyc) + cyc) % cyc;
`else
        if (n < 0) n = 0;
        if (n > cyc - 1) n = cyc - 1;
`endif
        return n;
    endfunction

    task automatic set_all(input int c, input int d, input int p);
        for (int i = 0; i < D; i++) begin
            cyc_a[i]   = W'(c);
            duty_a[i]  = W'(d);
            phase_a[i] = W'(p);
        end
    endtask

    task automatic do_reset(output int rel);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rel = cyc_cnt;
        for (int i = 0; i < D; i++) begin
            m_duty[i]  = 0;
            m_phase[i] = 0;
        end
        q_duty.delete();
        q_phase.delete();
    endtask

    // Waits for a sweep, pushes the model's expectations at its start and
    // compares them once DONE shows up. ovr_at > 0 also checks that OVERRUN
    // rises exactly ovr_at cycles after BUSY.
    task automatic do_sweep(input int ovr_at, output int b);
        int n;
        int ed;
        int ep;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (busy !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        b = cyc_cnt;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_rise: busy=%b after %0d cycles, required 1", busy, n);
            return;
        end
        for (int i = 0; i < D; i++) begin
            m_duty[i]  = model_duty(m_duty[i], int'(duty_a[i]), int'(cyc_a[i]), int'(STEP_DUTY));
            m_phase[i] = model_phase(m_phase[i], int'(phase_a[i]), int'(cyc_a[i]), int'(STEP_PHASE));
            q_duty.push_back(m_duty[i]);
            q_phase.push_back(m_phase[i]);
        end
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
            if (ovr_at > 0 && cyc_cnt - b == ovr_at - 1) begin
                tests_run++;
                if (overrun !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL overrun_early: overrun=%b, required 0", overrun);
                end
            end
            if (ovr_at > 0 && cyc_cnt - b == ovr_at) begin
                tests_run++;
                if (overrun !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL overrun_set: overrun=%b, required 1", overrun);
                end
            end
        end
        tests_run++;
        if (done !== 1'b1 || cyc_cnt - b != 250) begin
            tests_failed++;
            $display("FAIL done_latency: done=%b at %0d cycles after busy, required 1 at 250", done, cyc_cnt - b);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_fall: busy=%b with done, required 0", busy);
        end
        for (int i = 0; i < D; i++) begin
            ed = q_duty.pop_front();
            ep = q_phase.pop_front();
            tests_run++;
            if (duty_s[i] !== W'(ed)) begin
                tests_failed++;
                $display("FAIL duty_s[%0d]: got %0d, required %0d", i, duty_s[i], ed);
            end
            tests_run++;
            if (phase_s[i] !== W'(ep)) begin
                tests_failed++;
                $display("FAIL phase_s[%0d]: got %0d, required %0d", i, phase_s[i], ep);
            end
        end
        @(negedge CLK);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_reset();
        int rel;
        int nz;
        int nb;
        UPDATE_CYCLE = 16'd0;
        STEP_DUTY = W'(100);
        STEP_PHASE = W'(100);
        set_all(4096, 100, 100);
        do_reset(rel);
        nz = 0;
        for (int i = 0; i < D; i++) if (duty_s[i] !== '0 || phase_s[i] !== '0) nz++;
        tests_run++;
        if (nz != 0) begin
            tests_failed++;
            $display("FAIL reset_outputs: %0d nonzero channels, required 0", nz);
        end
        tests_run++;
        if ({busy, done, overrun} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/overrun=%b, required 000", {busy, done, overrun});
        end
        nb = 0;
        repeat (600) begin
            @(negedge CLK);
            if (busy !== 1'b0) nb++;
        end
        tests_run++;
        if (nb != 0) begin
            tests_failed++;
            $display("FAIL cycle_zero_idle: busy high %0d cycles, required 0", nb);
        end
    endtask

    task automatic test_sweep_timing();
        int rel;
        int b;
        int b2;
        int n;
        int c0;
        int c248;
        int cd;
        int ndone;
        logic busy_at_done;
        UPDATE_CYCLE = 16'd300;
        STEP_DUTY = W'(1);
        STEP_PHASE = W'(0);
        set_all(4096, 5, 0);
        do_reset(rel);
        n = 0;
        while (busy !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        b = cyc_cnt;
        tests_run++;
        if (busy !== 1'b1 || b - rel != 301) begin
            tests_failed++;
            $display("FAIL first_tick: busy=%b at %0d cycles after reset, required 1 at 301", busy, b - rel);
        end
        c0 = -1;
        c248 = -1;
        cd = -1;
        ndone = 0;
        busy_at_done = 1'bx;
        for (int k = 1; k <= 255; k++) begin
            @(negedge CLK);
            if (c0 < 0 && duty_s[0] !== '0) c0 = k;
            if (c248 < 0 && duty_s[D-1] !== '0) c248 = k;
            if (done === 1'b1) begin
                ndone++;
                if (cd < 0) begin
                    cd = k;
                    busy_at_done = busy;
                end
            end
        end
        tests_run++;
        if (c0 != 1) begin
            tests_failed++;
            $display("FAIL ch0_latency: updated %0d cycles after busy, required 1", c0);
        end
        tests_run++;
        if (c248 != 249) begin
            tests_failed++;
            $display("FAIL ch248_latency: updated %0d cycles after busy, required 249", c248);
        end
        tests_run++;
        if (cd != 250 || ndone != 1) begin
            tests_failed++;
            $display("FAIL done_once: first at %0d, count %0d, required 250 and 1", cd, ndone);
        end
        tests_run++;
        if (busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_with_done: busy=%b, required 0", busy_at_done);
        end
        for (int i = 0; i < D; i++) m_duty[i] = 1;
        do_sweep(-1, b2);
        tests_run++;
        if (b2 - b != 300) begin
            tests_failed++;
            $display("FAIL sweep_period: %0d cycles, required 300", b2 - b);
        end
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_overrun: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_duty_ramp();
        int rel;
        int b;
        int e;
        UPDATE_CYCLE = 16'd256;
        STEP_DUTY = W'(100);
        STEP_PHASE = W'(0);
        set_all(4096, 2000, 0);
        do_reset(rel);
        for (int k = 1; k <= 22; k++) begin
            do_sweep(-1, b);
            e = (k * 100 > 2000) ? 2000 : k * 100;
            tests_run++;
            if (duty_s[0] !== W'(e) || duty_s[200] !== W'(e)) begin
                tests_failed++;
                $display("FAIL duty_ramp[%0d]: got %0d/%0d, required %0d", k, duty_s[0], duty_s[200], e);
            end
        end
    endtask

    task automatic test_phase_path();
        int rel;
        int b;
        int seq [6];
`ifdef SILENCER_PHASE_WRAP_EN
        seq = '{4050, 4, 54, 100, 100, 100};
`else
        seq = '{3950, 3900, 3850, 3800, 3750, 3700};
`endif
        UPDATE_CYCLE = 16'd256;
        STEP_DUTY = W'(0);
        STEP_PHASE = W'(4095);
        set_all(4096, 700, 4000);
        do_reset(rel);
        do_sweep(-1, b);
        tests_run++;
        if (phase_s[0] !== W'(4000)) begin
            tests_failed++;
            $display("FAIL phase_one_step: got %0d, required 4000", phase_s[0]);
        end
        set_all(4096, 700, 100);
        phase_a[1] = W'(5000);
        STEP_PHASE = W'(50);
        for (int k = 0; k < 6; k++) begin
            do_sweep(-1, b);
            tests_run++;
            if (phase_s[0] !== W'(seq[k])) begin
                tests_failed++;
                $display("FAIL phase_path[%0d]: got %0d, required %0d", k, phase_s[0], seq[k]);
            end
            tests_run++;
            if (phase_s[1] !== W'(4000)) begin
                tests_failed++;
                $display("FAIL phase_hold[%0d]: got %0d, required 4000", k, phase_s[1]);
            end
            tests_run++;
            if (duty_s[3] !== '0) begin
                tests_failed++;
                $display("FAIL duty_frozen[%0d]: got %0d, required 0", k, duty_s[3]);
            end
        end
    endtask

    task automatic test_overrun();
        int rel;
        int b1;
        int b2;
        UPDATE_CYCLE = 16'd100;
        STEP_DUTY = W'(100);
        STEP_PHASE = W'(100);
        set_all(4096, 300, 200);
        do_reset(rel);
        do_sweep(100, b1);
        do_sweep(-1, b2);
        tests_run++;
        if (b2 - b1 != 300) begin
            tests_failed++;
            $display("FAIL overrun_restart: %0d cycles between sweeps, required 300", b2 - b1);
        end
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
    endtask

    task automatic test_reset_midsweep();
        int rel;
        int b;
        int n;
        int nz;
        int nd;
        UPDATE_CYCLE = 16'd256;
        STEP_DUTY = W'(100);
        STEP_PHASE = W'(100);
        set_all(4096, 1000, 500);
        do_reset(rel);
        n = 0;
        while (busy !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        b = cyc_cnt;
        while (cyc_cnt - b < 120) @(negedge CLK);
        tests_run++;
        if (duty_s[119] !== W'(100) || duty_s[120] !== '0) begin
            tests_failed++;
            $display("FAIL mid_progress: ch119=%0d ch120=%0d, required 100 and 0", duty_s[119], duty_s[120]);
        end
        RST = 1'b1;
        @(negedge CLK);
        nz = 0;
        for (int i = 0; i < D; i++) if (duty_s[i] !== '0 || phase_s[i] !== '0) nz++;
        tests_run++;
        if (nz != 0) begin
            tests_failed++;
            $display("FAIL abort_clear: %0d nonzero channels, required 0", nz);
        end
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_flags: busy/done=%b, required 00", {busy, done});
        end
        RST = 1'b0;
        for (int i = 0; i < D; i++) begin
            m_duty[i]  = 0;
            m_phase[i] = 0;
        end
        nd = 0;
        repeat (200) begin
            @(negedge CLK);
            if (done !== 1'b0) nd++;
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: %0d done cycles, required 0", nd);
        end
        do_sweep(-1, b);
    endtask

    task automatic test_random();
        int rel;
        int b;
        int c;
        int lim;
        UPDATE_CYCLE = 16'd256;
        STEP_DUTY = W'(100);
        STEP_PHASE = W'(100);
        for (int i = 0; i < D; i++) begin
            if (i % 8 == 0) begin
                c = int'($urandom_range(4000, 2000));
                duty_a[i] = W'(8191);
            end else begin
                c = int'($urandom_range(8000, 2000));
                lim = (c > 4000) ? 4000 : c;
                duty_a[i] = W'($urandom_range(lim, 0));
            end
            cyc_a[i] = W'(c);
            lim = (c - 1 > 4000) ? 4000 : c - 1;
            phase_a[i] = W'($urandom_range(lim, 0));
        end
        do_reset(rel);
        for (int k = 0; k < 40; k++) do_sweep(-1, b);
        for (int i = 0; i < D; i++) begin
            tests_run++;
            if (duty_s[i] !== ((duty_a[i] > cyc_a[i]) ? cyc_a[i] : duty_a[i])) begin
                tests_failed++;
                $display("FAIL converge_duty[%0d]: got %0d, target %0d cycle %0d", i, duty_s[i], duty_a[i], cyc_a[i]);
            end
            tests_run++;
            if (phase_s[i] !== phase_a[i]) begin
                tests_failed++;
                $display("FAIL converge_phase[%0d]: got %0d, required %0d", i, phase_s[i], phase_a[i]);
            end
        end
    endtask

    initial begin
        set_all(0, 0, 0);
        test_reset();
        test_sweep_timing();
        test_duty_ramp();
        test_phase_path();
        test_overrun();
        test_reset_midsweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
